bcd_load_seq: RTL and testbench
===============================

# bcd_load_seq

Upstream sequencer for the serial double-dabble display path. Accepts one parallel binary word per valid/ready handshake and clears the dabble register chain. Then streams the word MSB-first on `sdat`, one bit per clock, with a shift-enable, and issues a one-cycle latch strobe so the display holding registers capture the finished BCD digits. It drives the `sdat` input of the first dabble stage and the control lines shared by all three stages.

## Interface
Parameters:
- `WIDTH`, default 10: bit width of the binary input word. Range 4–16.
- `MAXVAL`, default 999: largest value representable on three digits. Used only under `BCD_LOAD_SAT_EN`.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in WIDTH: unsigned binary value to display.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word. High only in IDLE.
- `sdat` out 1: serial data bit to the first dabble stage, MSB first.
- `dab_clr` out 1: one-cycle synchronous clear for all dabble stages.
- `dab_en` out 1: shift enable for the dabble stages. Bit on `sdat` is consumed when high.
- `latch` out 1: one-cycle strobe. Display holding registers load BCD digits.
- `busy` out 1: conversion in progress.
- `ovf` out 1: last accepted word exceeded `MAXVAL`. Driven 0 without `BCD_LOAD_SAT_EN`.

## Operation
- All outputs are registered.
- FSM states: IDLE, CLEAR, SHIFT, LATCH.
- IDLE:
  - `in_ready`=1; all other strobes are 0.
  - On `in_valid`&&`in_ready`, capture `in_data` into shift register `sr`, load bit counter `cnt`=WIDTH-1, go to CLEAR.
- CLEAR (1 cycle): `dab_clr`=1, `in_ready`=0, `busy`=1. Next state is SHIFT.
- SHIFT (WIDTH cycles):
  - `dab_en`=1 and `sdat`=`sr[WIDTH-1]`.
  - Each cycle `sr` shifts left by one (zero fill) and `cnt` decrements.
  - When `cnt`==0 on a SHIFT cycle, next state is LATCH.
- LATCH (1 cycle): `latch`=1, `dab_en`=0, `sdat`=0. Next state is IDLE.
- Outside SHIFT, `sdat`=0 and `dab_en`=0.
- `in_valid` while not in IDLE is ignored. No word is captured and no error is flagged. The upstream source must hold `in_data` until accepted.
- Values above `MAXVAL` without `BCD_LOAD_SAT_EN`: shifted unchanged. The thousands carry from the last dabble stage is discarded, so the display shows the value mod 1000.
- Reset mid-operation:
  - State goes to IDLE immediately and `sr` and `cnt` clear.
  - No `latch` is issued; the displays keep their previous contents.
  - The word in flight is lost.

## Timing
- Reset values: `in_ready`=1; `sdat`, `dab_clr`, `dab_en`, `latch`, `busy`, `ovf` = 0.
- Handshake edge is cycle 0, where `in_valid`&&`in_ready` is sampled.
- Cycle 1: `dab_clr`=1.
- Cycles 2 … WIDTH+1: `dab_en`=1 and `sdat` carries bits WIDTH-1 … 0.
- Cycle WIDTH+2: `latch`=1.
- Cycle WIDTH+3: `in_ready`=1. A new word can be accepted on this edge.
- Throughput is one word per WIDTH+3 cycles: 13 cycles for WIDTH=10.
- `busy` is high on cycles 1 … WIDTH+2, exactly while `in_ready`=0.
- Only one strobe is high in any cycle: `dab_clr`, `dab_en` and `latch` are mutually exclusive.

## Configuration
- `BCD_LOAD_SAT_EN` defined:
  - At capture, if `in_data` > `MAXVAL`, `sr` loads `MAXVAL` and `ovf` is set to 1.
  - Otherwise `sr` loads `in_data` and `ovf` is set to 0.
  - `ovf` holds until the next accepted word or reset.
- Not defined: no comparator is built, `sr` always loads `in_data`, and `ovf` is constant 0.

## Test plan
- Reset release, idle 5 cycles -> `in_ready`=1; `sdat`, `dab_clr`, `dab_en`, `latch`, `busy` all 0 throughout.
- Load 10'd357 at cycle 0 -> `dab_clr` at cycle 1; `sdat` pattern 0101100101 on cycles 2–11 with `dab_en`=1; `latch` at cycle 12. Through the dabble chain, digits are 3,5,7.
- Hold `in_valid`=1 with values 100 then 200 back to back -> 100 is accepted at cycle 0 and 200 at cycle 13. No acceptance on cycles 1–12; displays show 100, then 200.
- Assert `rst` at cycle 6 of a conversion of 512 -> all outputs are at reset values in the same cycle. No `latch` pulse; `in_ready`=1 after release.
- Load 10'd1000: with `BCD_LOAD_SAT_EN`, `sdat` streams 1111100111 and `ovf`=1. Without it, `sdat` streams 1111101000, `ovf`=0 and the display reads 000.
- Load 0 -> `sdat` is all zeros for 10 cycles, `latch` at cycle 12, digits 0,0,0.

Source files
------------

// File: rtl/bcd_load_seq.sv
// Load sequencer for the serial double-dabble display path: clear, stream MSB-first, latch.
// Optional input saturation to MAXVAL is enabled by defining BCD_LOAD_SAT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a word, in_ready high
// ST_CLEAR | one-cycle clear of the dabble register chain
// ST_SHIFT | WIDTH cycles streaming sr MSB-first with dab_en
// ST_LATCH | one-cycle strobe so the displays capture the BCD digits
module bcd_load_seq #(
    parameter int WIDTH  = 10,
    parameter int MAXVAL = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdat,
    output logic             dab_clr,
    output logic             dab_en,
    output logic             latch,
    output logic             busy,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] load_val;

    logic in_ready_d, sdat_d, dab_clr_d, dab_en_d, latch_d, busy_d;

`ifdef BCD_LOAD_SAT_EN
    localparam int unsigned    MAXV = MAXVAL;
    localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAXVAL);

    logic over;
    logic ovf_q;

    assign over     = (32'(in_data) > MAXV);
    assign load_val = over ? MAXW : in_data;
    assign ovf      = ovf_q;

    // ovf reflects the most recently accepted word until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            ovf_q <= over;
        end
    end
`else
    assign load_val = in_data;
    assign ovf      = 1'b0;

    if (MAXVAL < 0) begin : g_maxval_range
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sr       <= '0;
            cnt      <= '0;
            in_ready <= 1'b1;
            sdat     <= 1'b0;
            dab_clr  <= 1'b0;
            dab_en   <= 1'b0;
            latch    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            cnt      <= cnt_nxt;
            in_ready <= in_ready_d;
            sdat     <= sdat_d;
            dab_clr  <= dab_clr_d;
            dab_en   <= dab_en_d;
            latch    <= latch_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_nxt    = load_val;
                    cnt_nxt   = CW'(WIDTH - 1);
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_nxt = {sr[WIDTH-2:0], 1'b0};
                if (cnt == '0) begin
                    state_nxt = ST_LATCH;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_LATCH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        in_ready_d = (state_nxt == ST_IDLE);
        busy_d     = (state_nxt != ST_IDLE);
        dab_clr_d  = (state_nxt == ST_CLEAR);
        dab_en_d   = (state_nxt == ST_SHIFT);
        latch_d    = (state_nxt == ST_LATCH);
        sdat_d     = dab_en_d & sr_nxt[WIDTH-1];
    end

endmodule

// File: tb/tb_bcd_load_seq.sv
// Randomized scoreboard bench for bcd_load_seq; mirrors BCD_LOAD_SAT_EN when defined.
module tb_bcd_load_seq;

    localparam int W    = 10;
    localparam int MAXV = 999;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready, sdat, dab_clr, dab_en, latch, busy, ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] word;
        bit           ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];

    bcd_load_seq #(.WIDTH(W), .MAXVAL(MAXV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sdat     (sdat),
        .dab_clr  (dab_clr),
        .dab_en   (dab_en),
        .latch    (latch),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef BCD_LOAD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic exp_t model(input int v, input int acc);
        exp_t e;
        bit   o;
        o     = SAT && (v > MAXV);
        e.word = o ? W'(MAXV) : W'(v);
        e.ovf  = o;
        e.acc  = acc;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic send(input int v, input bit keep, output int acc);
        bit done;
        done     = 1'b0;
        acc      = -1;
        in_data  = W'(v);
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                acc = cyc;
                sb.push_back(model(v, acc));
                if (!keep) in_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: reassembles each streamed word and checks it against the scoreboard.
    logic [W-1:0] mon_word;
    int           mon_bits;
    int           mon_clr;
    bit           mon_coll = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_coll = 1'b0;
        end else begin
            checks++;
            if ((int'(dab_clr) + int'(dab_en) + int'(latch)) > 1 || busy == in_ready || (!dab_en && sdat)) begin
                errors++;
                $display("FAIL invariant @%0d: clr=%0b en=%0b latch=%0b busy=%0b rdy=%0b sdat=%0b",
                         cyc, dab_clr, dab_en, latch, busy, in_ready, sdat);
            end
            if (dab_clr) begin
                if (mon_coll) check("clr_during_conversion", 1, 0);
                mon_coll = 1'b1;
                mon_word = '0;
                mon_bits = 0;
                mon_clr  = cyc;
            end else if (dab_en) begin
                if (!mon_coll) check("en_without_clr", 1, 0);
                mon_word = {mon_word[W-2:0], sdat};
                mon_bits++;
            end else if (latch) begin
                if (sb.size() == 0) begin
                    check("latch_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("stream_word", int'(mon_word), int'(e.word));
                    check("stream_bits", mon_bits, W);
                    check("ovf", int'(ovf), int'(e.ovf));
                    check("clr_cycle", mon_clr, e.acc);
                    check("latch_cycle", cyc, e.acc + W + 1);
                end
                mon_coll = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        check(name, int'({in_ready, sdat, dab_clr, dab_en, latch, busy}), 6'b100000);
    endtask

    initial begin
        int a1, a2, a;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_values");
        check("reset_ovf", int'(ovf), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_idle_outputs("idle_after_reset");
        end

        send(357, 1'b0, a);
        repeat (15) @(posedge clk);
        #1;
        send(0, 1'b0, a);
        repeat (15) @(posedge clk);
        #1;
        send(1000, 1'b0, a);
        repeat (15) @(posedge clk);
        #1;
        send(1023, 1'b0, a);
        repeat (15) @(posedge clk);
        #1;

        send(100, 1'b1, a1);
        send(200, 1'b0, a2);
        check("back_to_back_spacing", a2 - a1, W + 3);
        repeat (15) @(posedge clk);
        #1;

        // Reset mid-conversion: the in-flight word must vanish without a latch.
        send(512, 1'b0, a);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_midway");
        check("reset_midway_ovf", int'(ovf), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_after_release", int'(in_ready), 1);
        repeat (W + 4) @(posedge clk);
        #1;
        check_idle_outputs("quiet_after_reset");

        for (int i = 0; i < 40; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 1023);
            send(v, 1'b0, a);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
